// File: rtl/game_flow_ctrl.sv
// Game sequencer for the Mario playfield: start/over pulses, lives and level timer.
// Screen code on game_state: 0 idle, 1 playing, 2 dying, 3 game over, 4 win.
module game_flow_ctrl #(
    parameter int LIVES_INIT     = 3,
    parameter int TIME_INIT      = 400,
    parameter int FRAMES_PER_SEC = 60,
    parameter int DEATH_FRAMES   = 120,
    parameter int END_FRAMES     = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       frame_tick,
    input  logic       mario_dead,
    input  logic       reach_goal,
    output logic       start,
    output logic       over,
    output logic [2:0] game_state,
    output logic [2:0] lives,
    output logic [9:0] time_left
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PLAY = 3'd1;
    localparam logic [2:0] S_DIE  = 3'd2;
    localparam logic [2:0] S_GO   = 3'd3;
    localparam logic [2:0] S_WIN  = 3'd4;

    localparam logic [2:0] LIVES_RST  = 3'(LIVES_INIT);
    localparam logic [9:0] TIME_RST   = 10'(TIME_INIT);
    localparam logic [7:0] SEC_LAST   = 8'(FRAMES_PER_SEC - 1);
    localparam logic [7:0] DEATH_LAST = 8'(DEATH_FRAMES - 1);
    localparam logic [7:0] END_LAST   = 8'(END_FRAMES - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [9:0] time_q, time_d;
    logic [7:0] sec_q, sec_d;
    logic [7:0] wait_q, wait_d;
    logic       start_q, start_d;
    logic       over_q, over_d;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        time_d  = time_q;
        sec_d   = sec_q;
        wait_d  = wait_q;
        start_d = 1'b0;
        over_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_btn) begin
                    state_d = S_PLAY;
                    start_d = 1'b1;
                    time_d  = TIME_RST;
                    sec_d   = '0;
                    wait_d  = '0;
                end
            end
            S_PLAY: begin
                if (reach_goal) begin
                    state_d = S_WIN;
                    over_d  = 1'b1;
                    sec_d   = '0;
                    wait_d  = '0;
                end else if (mario_dead || time_q == '0) begin
                    state_d = S_DIE;
                    over_d  = 1'b1;
                    lives_d = (lives_q == '0) ? '0 : lives_q - 3'd1;
                    sec_d   = '0;
                    wait_d  = '0;
                end else if (frame_tick) begin
                    // time_q is nonzero here, so the decrement cannot wrap
                    if (sec_q == SEC_LAST) begin
                        sec_d  = '0;
                        time_d = time_q - 10'd1;
                    end else begin
                        sec_d = sec_q + 8'd1;
                    end
                end
            end
            S_DIE: begin
                if (frame_tick) begin
                    if (wait_q == DEATH_LAST) begin
                        wait_d = '0;
                        sec_d  = '0;
                        if (lives_q == '0) begin
                            state_d = S_GO;
                        end else begin
                            state_d = S_PLAY;
                            start_d = 1'b1;
                            time_d  = TIME_RST;
                        end
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            S_GO, S_WIN: begin
                if (frame_tick) begin
                    if (wait_q == END_LAST) begin
                        state_d = S_IDLE;
                        lives_d = LIVES_RST;
                        time_d  = TIME_RST;
                        wait_d  = '0;
                        sec_d   = '0;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                lives_d = LIVES_RST;
                time_d  = TIME_RST;
                sec_d   = '0;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lives_q <= LIVES_RST;
            time_q  <= TIME_RST;
            sec_q   <= '0;
            wait_q  <= '0;
            start_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            time_q  <= time_d;
            sec_q   <= sec_d;
            wait_q  <= wait_d;
            start_q <= start_d;
            over_q  <= over_d;
        end
    end

    assign start      = start_q;
    assign over       = over_q;
    assign game_state = state_q;
    assign lives      = lives_q;
    assign time_left  = time_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: frame-count reference model feeds a queue,
// a monitor pops one expected output set per clock.
module tb_game_flow_ctrl;

    localparam int LI  = 2;
    localparam int TI  = 3;
    localparam int FPS = 2;
    localparam int DF  = 4;
    localparam int EF  = 4;

    logic       clk = 1'b0;
    logic       rst, start_btn, frame_tick, mario_dead, reach_goal;
    logic       start, over;
    logic [2:0] game_state, lives;
    logic [9:0] time_left;

    always #5 clk = ~clk;

    game_flow_ctrl #(
        .LIVES_INIT(LI), .TIME_INIT(TI), .FRAMES_PER_SEC(FPS),
        .DEATH_FRAMES(DF), .END_FRAMES(EF)
    ) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn),
        .frame_tick(frame_tick), .mario_dead(mario_dead),
        .reach_goal(reach_goal), .start(start), .over(over),
        .game_state(game_state), .lives(lives), .time_left(time_left)
    );

    typedef struct {
        int st;
        int lv;
        int tm;
        int sp;
        int op;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: per-state frame count; timer derived by division.
    int m_st = 0;
    int m_lv = LI;
    int m_frames = 0;
    int m_hold = TI;
    int m_sp = 0;
    int m_op = 0;

    function automatic int play_time(int frames);
        int t;
        t = TI - frames / FPS;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic void model_step(bit r, bit b, bit t, bit d, bit g);
        int tl;
        m_sp = 0;
        m_op = 0;
        if (r) begin
            m_st = 0; m_lv = LI; m_frames = 0; m_hold = TI;
            return;
        end
        case (m_st)
            0: if (b) begin
                m_st = 1; m_frames = 0; m_sp = 1;
            end
            1: begin
                tl = play_time(m_frames);
                if (g) begin
                    m_st = 4; m_op = 1; m_hold = tl; m_frames = 0;
                end else if (d || tl == 0) begin
                    m_st = 2; m_op = 1; m_hold = tl; m_frames = 0;
                    m_lv = (m_lv > 0) ? m_lv - 1 : 0;
                end else if (t) begin
                    m_frames++;
                end
            end
            2: if (t) begin
                m_frames++;
                if (m_frames == DF) begin
                    m_frames = 0;
                    if (m_lv == 0) m_st = 3;
                    else begin m_st = 1; m_sp = 1; end
                end
            end
            default: if (t) begin
                m_frames++;
                if (m_frames == EF) begin
                    m_st = 0; m_frames = 0; m_lv = LI; m_hold = TI;
                end
            end
        endcase
    endfunction

    task automatic cyc(bit r, bit b, bit t, bit d, bit g);
        exp_t e;
        @(negedge clk);
        rst = r; start_btn = b; frame_tick = t;
        mario_dead = d; reach_goal = g;
        model_step(r, b, t, d, g);
        e.st = m_st;
        e.lv = m_lv;
        e.tm = (m_st == 1) ? play_time(m_frames) : m_hold;
        e.sp = m_sp;
        e.op = m_op;
        exp_q.push_back(e);
    endtask

    task automatic chk(string name, int act, int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, act, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("game_state", int'(game_state), e.st);
                chk("lives", int'(lives), e.lv);
                chk("time_left", int'(time_left), e.tm);
                chk("start", int'(start), e.sp);
                chk("over", int'(over), e.op);
                chk("start_over_excl", int'(start & over), 0);
            end
        end
    end

    initial begin : stim
        rst = 1'b1; start_btn = 1'b0; frame_tick = 1'b0;
        mario_dead = 1'b0; reach_goal = 1'b0;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        // start, run the timer down, die
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // simultaneous goal and death
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
        // reset in dying with start_btn held
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // start_btn held through win
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
                $urandom_range(0, 39) == 0);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer for the Mario playfield.
- Generates the single-cycle start and over pulses that move the sprite blocks (Mario, Peach/queue, enemies) between their INITIAL and PLAYING states.
- Tracks lives and the level countdown timer.
- Exposes a game-state code to the renderer so it can select the title, play, death, game-over and win screens.

Parameters:
- LIVES_INIT, 3, lives loaded at reset and on return to IDLE (1..7).
- TIME_INIT, 400, level timer in seconds, loaded on every entry to PLAYING (1..1023).
- FRAMES_PER_SEC, 60, frame_tick pulses per timer decrement (1..255).
- DEATH_FRAMES, 120, frame_tick pulses spent in DYING (1..255).
- END_FRAMES, 180, frame_tick pulses spent in WIN or GAME_OVER (1..255).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- start_btn  input  1  level; request to begin a game.
- frame_tick  input  1  one-cycle pulse per video frame.
- mario_dead  input  1  level; Mario hit an enemy or fell.
- reach_goal  input  1  level; Mario touched the queue or flag.
- start  output  1  one-cycle pulse to the sprite blocks.
- over  output  1  one-cycle pulse to the sprite blocks.
- game_state  output  3  0=IDLE, 1=PLAYING, 2=DYING, 3=GAME_OVER, 4=WIN.
- lives  output  3  remaining lives.
- time_left  output  10  seconds remaining.

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - rst has priority over every other input.
  - On a clocked rst: game_state=IDLE, lives=LIVES_INIT, time_left=TIME_INIT, start=0, over=0, all internal counters 0.
  - rst asserted mid-operation in any state returns to IDLE on that edge with the same values. No over pulse is issued for a reset.
- Outputs and counters:
  - All outputs are registered. The state change and its associated pulse appear on the same edge.
  - Internal counters: sec_cnt (8b) counts frame_tick in PLAYING; wait_cnt (8b) counts frame_tick in DYING/WIN/GAME_OVER. Both clear on every state change.
- IDLE:
  - start_btn=1 -> PLAYING on that edge, with start=1 for exactly that one cycle and time_left=TIME_INIT.
  - mario_dead and reach_goal are ignored.
- PLAYING:
  - Each frame_tick increments sec_cnt.
  - When sec_cnt==FRAMES_PER_SEC-1 and frame_tick=1: sec_cnt->0 and time_left decrements by 1. time_left never wraps below 0.
  - Exit priority, evaluated every cycle: reach_goal first, then (mario_dead or time_left==0).
  - If reach_goal=1 -> WIN, over=1 for one cycle. lives is unchanged.
  - Else if mario_dead=1 or time_left==0 -> DYING, over=1 for one cycle, lives decremented on the same edge (saturating at 0).
  - If reach_goal and mario_dead are high in the same cycle, the result is WIN.
  - start_btn is ignored.
- DYING:
  - Count frame_tick in wait_cnt.
  - On the frame_tick where wait_cnt==DEATH_FRAMES-1:
    - if lives==0 -> GAME_OVER;
    - else -> PLAYING, with start=1 for one cycle and time_left=TIME_INIT.
  - All game inputs are ignored.
- WIN / GAME_OVER:
  - Count frame_tick.
  - On the frame_tick where wait_cnt==END_FRAMES-1 -> IDLE, lives=LIVES_INIT, time_left=TIME_INIT.
  - A start_btn held high during this period is not acted on until the cycle after IDLE is entered. The minimum latency from the end of WIN/GAME_OVER to start is 1 cycle.
- Pulse rules:
  - start and over are never high in the same cycle.
  - Each is high for at most one consecutive cycle.
  - frame_tick is assumed to be a single-cycle pulse; a held frame_tick counts once per cycle.

Test Plan:
Parameters for all scenarios: LIVES_INIT=2, TIME_INIT=3, FRAMES_PER_SEC=2, DEATH_FRAMES=4, END_FRAMES=4.
1. Reset, then start_btn=1 for 1 cycle -> next edge game_state=1, start=1 for exactly one cycle, time_left=3, lives=2.
2. PLAYING with 6 frame_ticks and no events -> time_left 3->2->1->0 after ticks 2, 4 and 6. The cycle after time_left=0: game_state=2, over=1, lives=1.
3. From DYING with lives=1, 4 frame_ticks -> game_state=1, start=1, time_left=3. Then mario_dead=1 -> DYING with lives=0; 4 more ticks -> game_state=3. 4 more ticks -> game_state=0, lives=2.
4. PLAYING with mario_dead=1 and reach_goal=1 in the same cycle -> game_state=4, over=1, lives stays 2. After 4 ticks -> IDLE.
5. rst=1 during DYING (wait_cnt=2) -> next edge game_state=0, lives=2, time_left=3, over=0, start=0. A start_btn held high together with rst -> stays IDLE.
6. start_btn held high across the whole of WIN -> IDLE entered for 1 cycle, then PLAYING with start=1. start and over are never both high anywhere in the run.
